// File: rtl/tmod_arbiter.sv
// Round-robin arbiter that serialises requester commands onto a single
// temperature-slave command port, with response timeout and NOOP bypass.
//
// state    | meaning
// IDLE     | no transaction; pick the next requester round-robin
// GRANT    | winner latched, one-cycle gnt pulse
// ISSUE    | s_start high until the slave accepts (s_ready)
// WAIT_RSP | timer running until s_valid or timeout
// RESP     | one-cycle rsp_valid pulse to the winner
module tmod_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_opnd,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [3:0]        s_op,
  output logic [7:0]        s_opnd,
  output logic              s_start,
  input  logic              s_ready,
  input  logic              s_valid,
  input  logic [7:0]        s_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT_RSP, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [3:0]    op_q;
  logic [7:0]    opnd_q;
  logic [7:0]    data_q;
  logic          err_q;
  logic [TW-1:0] timer;

  logic [PW-1:0] win;
  logic [3:0]    win_op;
  logic [7:0]    win_opnd;

  // Scan from ptr+NREQ (== ptr, lowest priority) down to ptr+1, so the
  // requester just after ptr overwrites everything else and wins.
  always_comb begin
    int c;
    c   = 0;
    win = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (req[PW'(c)]) win = PW'(c);
    end
  end

  always_comb begin
    win_op   = '0;
    win_opnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        win_op   = req_op[4*i +: 4];
        win_opnd = req_opnd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= PW'(NREQ - 1);
      op_q   <= '0;
      opnd_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ptr    <= win;
            op_q   <= win_op;
            opnd_q <= win_opnd;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (op_q[3]) begin
            data_q <= '0;
            err_q  <= 1'b0;
            state  <= RESP;
          end else begin
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_ready) begin
            timer <= '0;
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response arriving on the timeout cycle still counts as good.
          if (s_valid) begin
            data_q <= s_data;
            err_q  <= 1'b0;
            state  <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign s_start   = (state == ISSUE);
  assign s_op      = op_q;
  assign s_opnd    = opnd_q;
  assign gnt       = (state == GRANT) ? (NREQ'(1) << ptr) : '0;
  assign rsp_valid = (state == RESP)  ? (NREQ'(1) << ptr) : '0;
  assign rsp_data  = data_q;
  assign rsp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_tmod_arbiter.sv
// Scoreboard bench for tmod_arbiter: expected responses are queued when a
// command is driven and matched against responses captured by a monitor.
module tb_tmod_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_op;
  logic [31:0] req_opnd;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [3:0]  s_op;
  logic [7:0]  s_opnd;
  logic        s_start;
  logic        s_ready;
  logic        s_valid;
  logic [7:0]  s_data;

  tmod_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_opnd(req_opnd),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .s_op(s_op), .s_opnd(s_opnd), .s_start(s_start),
    .s_ready(s_ready), .s_valid(s_valid), .s_data(s_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic [7:0] data;
    logic       err;
    int         cyc;
  } rsp_t;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } gnt_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  gnt_t gnt_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc++;

  // Monitor only records; all comparisons happen in the test tasks.
  always @(negedge clk) begin
    rsp_t r;
    gnt_t g;
    if (|rsp_valid) begin
      r.vec = rsp_valid; r.data = rsp_data; r.err = rsp_err; r.cyc = cyc;
      obs_q.push_back(r);
    end
    if (|gnt) begin
      g.vec = gnt; g.cyc = cyc;
      gnt_q.push_back(g);
    end
  end

  task automatic set_cmd(input int i, input logic [3:0] op, input logic [7:0] opnd);
    req_op[4*i +: 4]   = op;
    req_opnd[8*i +: 8] = opnd;
  endtask

  task automatic push_exp(input logic [3:0] vec, input logic [7:0] data, input logic err, input int c);
    rsp_t e;
    e.vec = vec; e.data = data; e.err = err; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_op = '0; req_opnd = '0;
    s_ready = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, s_start, busy, rsp_err} !== 11'b0)
      begin errors++; $display("FAIL reset_ctrl got %b want 0", {gnt, rsp_valid, s_start, busy, rsp_err}); end
    checks++;
    if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    checks++;
    if ({s_op, s_opnd} !== 12'h000) begin errors++; $display("FAIL reset_s_cmd got %h want 000", {s_op, s_opnd}); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    obs_q.delete(); gnt_q.delete(); exp_q.delete();
  endtask

  task automatic test_noop_rr();
    int   t0;
    gnt_t g;
    rsp_t e, o;
    gnt_q.delete();
    for (int i = 0; i < 4; i++) set_cmd(i, 4'h8, 8'(16 * i + 3));
    req = 4'b1111;
    t0 = cyc;
    push_exp(4'b0001, 8'h00, 1'b0, t0 + 2);
    push_exp(4'b0010, 8'h00, 1'b0, -1);
    push_exp(4'b0100, 8'h00, 1'b0, -1);
    push_exp(4'b1000, 8'h00, 1'b0, -1);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      req = req & ~gnt;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_q.size() == 0) begin errors++; $display("FAIL noop_gnt_order got none want idx %0d", i); end
      else begin
        g = gnt_q.pop_front();
        if (g.vec !== (4'b0001 << i)) begin errors++; $display("FAIL noop_gnt_order got %b want %b", g.vec, 4'b0001 << i); end
        else if (i == 0 && g.cyc - t0 != 1) begin errors++; $display("FAIL noop_gnt_latency got %0d want 1", g.cyc - t0); end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL noop_rsp got none want %b", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.data !== e.data || o.err !== e.err || (e.cyc >= 0 && o.cyc != e.cyc))
          begin errors++; $display("FAIL noop_rsp got %b/%h/%b@%0d want %b/%h/%b@%0d", o.vec, o.data, o.err, o.cyc, e.vec, e.data, e.err, e.cyc); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL noop_extra_rsp got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_slave_op();
    int   t0, start_cyc;
    bit   pending;
    rsp_t e, o;
    start_cyc = -1; pending = 0;
    set_cmd(2, 4'h4, 8'h37);
    s_ready = 1'b1;
    req = 4'b0100;
    t0 = cyc;
    push_exp(4'b0100, 8'h5A, 1'b0, t0 + 4);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      req = req & ~gnt;
      s_valid = 1'b0;
      if (pending) begin s_valid = 1'b1; s_data = 8'h5A; pending = 0; end
      if (s_start) begin
        checks++;
        if (s_op !== 4'h4 || s_opnd !== 8'h37) begin errors++; $display("FAIL slave_cmd got %h/%h want 4/37", s_op, s_opnd); end
        start_cyc = cyc; pending = 1;
      end
    end
    checks++;
    if (start_cyc - t0 != 2) begin errors++; $display("FAIL slave_start_latency got %0d want 2", start_cyc - t0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL slave_rsp got none want %b", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc)
          begin errors++; $display("FAIL slave_rsp got %b/%h/%b@%0d want %b/%h/%b@%0d", o.vec, o.data, o.err, o.cyc, e.vec, e.data, e.err, e.cyc); end
      end
    end
  endtask

  task automatic test_ready_stall();
    int   nstart;
    bit   pending;
    rsp_t e, o;
    nstart = 0; pending = 0;
    set_cmd(0, 4'h2, 8'hA1);
    s_ready = 1'b0;
    req = 4'b0001;
    push_exp(4'b0001, 8'hC3, 1'b0, -1);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      req = req & ~gnt;
      s_valid = 1'b0; s_ready = 1'b0;
      if (pending) begin s_valid = 1'b1; s_data = 8'hC3; pending = 0; end
      if (s_start) begin
        nstart++;
        checks++;
        if (s_op !== 4'h2 || s_opnd !== 8'hA1) begin errors++; $display("FAIL stall_cmd_stable got %h/%h want 2/A1", s_op, s_opnd); end
        if (nstart == 6) begin s_ready = 1'b1; pending = 1; end
        else begin s_valid = 1'b1; s_data = 8'hEE; end
      end
    end
    checks++;
    if (nstart != 6) begin errors++; $display("FAIL stall_start_cycles got %0d want 6", nstart); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stall_rsp got none want %b", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.data !== e.data || o.err !== e.err)
          begin errors++; $display("FAIL stall_rsp got %b/%h/%b want %b/%h/%b", o.vec, o.data, o.err, e.vec, e.data, e.err); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL stall_extra_rsp got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    int   start_cyc;
    rsp_t e, o;
    // No response at all: error exactly 16 cycles after WAIT_RSP entry.
    start_cyc = -1;
    set_cmd(1, 4'h1, 8'h10);
    s_ready = 1'b1; s_valid = 1'b0;
    req = 4'b0010;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (s_start) begin start_cyc = cyc; push_exp(4'b0010, 8'h00, 1'b1, cyc + 17); end
    end
    // Response on the last allowed cycle beats the timeout.
    start_cyc = -1;
    set_cmd(3, 4'h3, 8'h30);
    req = 4'b1000;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      req = req & ~gnt;
      s_valid = 1'b0;
      if (s_start) begin start_cyc = cyc; push_exp(4'b1000, 8'h77, 1'b0, cyc + 17); end
      if (start_cyc >= 0 && cyc == start_cyc + 16) begin s_valid = 1'b1; s_data = 8'h77; end
    end
    s_valid = 1'b0;
    checks++;
    if (exp_q.size() != 2) begin errors++; $display("FAIL timeout_issue_count got %0d want 2", exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL timeout_rsp got none want %b", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.data !== e.data || o.err !== e.err || o.cyc != e.cyc)
          begin errors++; $display("FAIL timeout_rsp got %b/%h/%b@%0d want %b/%h/%b@%0d", o.vec, o.data, o.err, o.cyc, e.vec, e.data, e.err, e.cyc); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   ng;
    gnt_t g;
    rsp_t e, o;
    gnt_q.delete();
    ng = 0;
    set_cmd(1, 4'h8, 8'h01);
    set_cmd(3, 4'h9, 8'h03);
    req = 4'b1010;
    for (int i = 0; i < 2; i++) begin
      push_exp(4'b0010, 8'h00, 1'b0, -1);
      push_exp(4'b1000, 8'h00, 1'b0, -1);
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (|gnt) begin ng++; if (ng == 4) req = '0; end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_q.size() == 0) begin errors++; $display("FAIL alt_gnt_order got none at %0d", i); end
      else begin
        g = gnt_q.pop_front();
        if (g.vec !== ((i % 2 == 0) ? 4'b0010 : 4'b1000))
          begin errors++; $display("FAIL alt_gnt_order got %b want %b", g.vec, (i % 2 == 0) ? 4'b0010 : 4'b1000); end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL alt_rsp got none want %b", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.data !== e.data || o.err !== e.err)
          begin errors++; $display("FAIL alt_rsp got %b/%h/%b want %b/%h/%b", o.vec, o.data, o.err, e.vec, e.data, e.err); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   seen;
    gnt_t g;
    rsp_t e, o;
    seen = 0;
    set_cmd(2, 4'h5, 8'h42);
    s_ready = 1'b1; s_valid = 1'b0;
    req = 4'b0100;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (s_start) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_issue got none want s_start"); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, s_start, rsp_valid} !== 6'b0) begin errors++; $display("FAIL midrst_state got %b want 0", {busy, s_start, rsp_valid}); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_no_rsp got %0d want 0", obs_q.size()); obs_q.delete(); end
    gnt_q.delete();
    for (int i = 0; i < 4; i++) set_cmd(i, 4'h8, 8'h00);
    req = 4'b1111;
    push_exp(4'b0001, 8'h00, 1'b0, -1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (|gnt) req = '0;
    end
    checks++;
    if (gnt_q.size() == 0) begin errors++; $display("FAIL midrst_first_gnt got none want 0001"); end
    else begin
      g = gnt_q.pop_front();
      if (g.vec !== 4'b0001) begin errors++; $display("FAIL midrst_first_gnt got %b want 0001", g.vec); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midrst_rsp got none want %b", e.vec); end
      else begin
        o = obs_q.pop_front();
        if (o.vec !== e.vec || o.data !== e.data || o.err !== e.err)
          begin errors++; $display("FAIL midrst_rsp got %b/%h/%b want %b/%h/%b", o.vec, o.data, o.err, e.vec, e.data, e.err); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_noop_rr();
    test_slave_op();
    test_ready_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmod_arbiter.md
TMOD_ARBITER -- requirements
Module: tmod_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent waiting for a slave response (>=2).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  NREQ  SHALL be the per-requester command request, held until granted.
REQ-006 req_op  input  4*NREQ  SHALL carry the opcode of requester i in bits [4i+3:4i].
REQ-007 req_opnd  input  8*NREQ  SHALL carry the operand of requester i in bits [8i+7:8i].
REQ-008 gnt  output  NREQ  SHALL be a one-hot, one-cycle grant pulse.
REQ-009 rsp_valid  output  NREQ  SHALL be a one-hot, one-cycle completion pulse to the granted requester.
REQ-010 rsp_data  output  8  SHALL be the response data, valid when any rsp_valid bit is high.
REQ-011 rsp_err  output  1  SHALL flag a timed-out transaction, valid with rsp_valid.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-013 s_op  output  4  SHALL be the opcode presented to the temperature slave.
REQ-014 s_opnd  output  8  SHALL be the operand presented to the slave.
REQ-015 s_start  output  1  SHALL be the command-issue strobe to the slave.
REQ-016 s_ready  input  1  SHALL indicate that the slave accepts a command this cycle.
REQ-017 s_valid  input  1  SHALL indicate that the slave's response data is valid this cycle.
REQ-018 s_data  input  8  SHALL be the slave response data.

Function
REQ-019 The FSM SHALL have the states IDLE, GRANT, ISSUE, WAIT_RSP and RESP, and all outputs SHALL be registered or decoded from state and registers only.
REQ-020 In IDLE with any req bit high, the FSM SHALL select a winner round-robin, searching from ptr+1 upward with wrap, and SHALL go to GRANT.
REQ-021 Entering GRANT, the block SHALL latch the winner's op and opnd, set ptr to the winner, and assert gnt[winner] for exactly that one cycle.
REQ-022 From GRANT, op[3]=1 (NOOP) SHALL go to RESP without touching the slave; otherwise the FSM SHALL go to ISSUE.
REQ-023 In ISSUE: s_start=1 and s_op/s_opnd = latched values; the FSM SHALL stay while s_ready=0 and go to WAIT_RSP on the edge where s_ready=1, with timer cleared.
REQ-024 s_op and s_opnd SHALL hold their latched values from GRANT through RESP, and s_start SHALL be 0 outside ISSUE.
REQ-025 In WAIT_RSP the timer SHALL increment each cycle; s_valid=1 SHALL capture s_data with err=0 and go to RESP.
REQ-026 When timer reaches TIMEOUT-1 with s_valid=0, the FSM SHALL go to RESP with data=0x00 and err=1.
REQ-027 If s_valid and timeout coincide, s_valid SHALL win (err=0).
REQ-028 In RESP: rsp_valid[winner]=1 for one cycle with rsp_data/rsp_err, then IDLE; NOOP responses SHALL be data 0x00, err 0.
REQ-029 A req still high in IDLE after its own response SHALL be treated as a new request and ranked behind other pending requesters.
REQ-030 s_valid outside WAIT_RSP SHALL be ignored.
REQ-031 Latency, NOOP: req sampled at edge 0 -> gnt during cycle 1 -> rsp_valid during cycle 2.
REQ-032 Latency, slave op with s_ready=1 and a 1-cycle response: gnt in cycle 1, s_start in cycle 2, WAIT_RSP in cycle 3, rsp_valid in cycle 4.

Reset
REQ-033 On reset the state SHALL be IDLE, gnt/rsp_valid/s_start/busy/rsp_err SHALL be 0, rsp_data/s_op/s_opnd SHALL be 0, ptr SHALL be NREQ-1 and timer SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no rsp_valid, and s_start SHALL be low the cycle after the reset edge.

Verification
REQ-035 The bench SHALL cover: after reset, req=4'b1111, all NOOP -> gnt order 0,1,2,3, each rsp_valid with data 0x00, err 0.
REQ-036 The bench SHALL cover: req[2] op=4'h4, s_ready=1, s_valid one cycle after issue with s_data=0x5A -> rsp_valid[2], rsp_data=0x5A, rsp_err=0, cycle counts per REQ-032.
REQ-037 The bench SHALL cover: s_ready held 0 for 5 cycles -> s_start stays 1 for 6 cycles, op/opnd stable, exactly one acceptance.
REQ-038 The bench SHALL cover: no s_valid with TIMEOUT=16 -> rsp_err=1, rsp_data=0x00 exactly 16 cycles after WAIT_RSP entry; s_valid on the final cycle -> err=0.
REQ-039 The bench SHALL cover: req[1] held continuously while req[3] pending -> grants alternate 1,3,1,3.
REQ-040 The bench SHALL cover: reset during WAIT_RSP -> no rsp_valid, busy=0 and ptr=NREQ-1 (next grant goes to requester 0).
